iec_sd_arbiter: RTL

Shares the single MiSTer SD block channel between up to four IEC drive requesters, which each present their own per-drive `sd_lba`, `sd_blk_cnt`, `sd_rd` and `sd_wr`. The block sits in the `clk_sys` domain between the drive selector and the HPS block interface. It grants one drive at a time in round-robin order and latches that drive's command. It routes the ack and buffer strobes only to the granted drive, and it recovers from a host that never acknowledges. `sd_buff_addr` and `sd_buff_dout` remain broadcast to all drives outside this block.

---
 rtl/iec_sd_arbiter_if.sv | 37 +++
 rtl/iec_sd_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/iec_sd_arbiter_if.sv
// Bundle of the per-drive request/ack lines and the shared host SD block channel.
// The arbiter takes the slave side; the drive/host environment takes the master side.
interface iec_sd_arbiter_if #(
    parameter int DRIVES = 2
);
    localparam int NDR = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES);

    logic [31:0]    drv_lba      [NDR];
    logic [5:0]     drv_blk_cnt  [NDR];
    logic [7:0]     drv_buff_din [NDR];
    logic [NDR-1:0] drv_rd;
    logic [NDR-1:0] drv_wr;
    logic [NDR-1:0] drv_ack;
    logic [NDR-1:0] drv_buff_wr;

    logic [31:0]    sd_lba;
    logic [5:0]     sd_blk_cnt;
    logic           sd_rd;
    logic           sd_wr;
    logic           sd_ack;
    logic           sd_buff_wr;
    logic [7:0]     sd_buff_din;

    modport slave (
        input  drv_lba, drv_blk_cnt, drv_buff_din, drv_rd, drv_wr,
        input  sd_ack, sd_buff_wr,
        output drv_ack, drv_buff_wr,
        output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din
    );

    modport master (
        output drv_lba, drv_blk_cnt, drv_buff_din, drv_rd, drv_wr,
        output sd_ack, sd_buff_wr,
        input  drv_ack, drv_buff_wr,
        input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter sharing one SD block channel among up to four IEC drives,
// latching the winner's command and abandoning requests the host never acks.
module iec_sd_arbiter #(
    parameter int DRIVES = 2,
    parameter int TMO_W  = 20
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    iec_sd_arbiter_if.slave    bus,
    output logic               busy,
    output logic [1:0]         grant,
    output logic               tmo
);
    localparam int NDR = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES);
    localparam int IW  = (NDR > 1) ? $clog2(NDR) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_grant;
    logic [1:0]       r_last;
    logic [31:0]      r_lba;
    logic [5:0]       r_blkCnt;
    logic             r_dirRd;
    logic [TMO_W-1:0] r_tmoCnt;
    logic             r_tmo;

    logic [NDR-1:0]   w_req;
    logic [3:0]       w_reqPad;
    logic             w_winValid;
    logic [1:0]       w_winIdx;
    logic [IW-1:0]    w_winSel;
    logic [IW-1:0]    w_gSel;
    logic [TMO_W-1:0] w_cntNext;
    logic             w_cntLast;
    logic             w_sdRd;
    logic             w_sdWr;
    logic             w_ackWin;
    logic             w_bufWin;
    logic [NDR-1:0]   w_drvAck;
    logic [NDR-1:0]   w_drvBufWr;

    assign w_req     = bus.drv_rd | bus.drv_wr;
    assign w_reqPad  = 4'(w_req);
    assign w_winSel  = w_winIdx[IW-1:0];
    assign w_gSel    = r_grant[IW-1:0];
    assign w_cntNext = r_tmoCnt + TMO_W'(1);
    assign w_cntLast = &w_cntNext;

    // Search starts one past the previous grant so every requester waits at most NDR-1 turns.
    always_comb begin
        logic [1:0] idx;
        w_winValid = 1'b0;
        w_winIdx   = r_last;
        idx        = 2'd0;
        for (int k = 1; k <= NDR; k++) begin
            idx = 2'((int'(r_last) + k) % NDR);
            if (!w_winValid && w_reqPad[idx]) begin
                w_winValid = 1'b1;
                w_winIdx   = idx;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_winValid) w_nextState = REQ;
            REQ: begin
                if (bus.sd_ack) begin
                    w_nextState = XFER;
                end else if (w_cntLast) begin
                    w_nextState = IDLE;
                end
            end
            XFER: if (!bus.sd_ack) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_grant  <= 2'd0;
            r_last   <= 2'(NDR - 1);
            r_lba    <= 32'd0;
            r_blkCnt <= 6'd0;
            r_dirRd  <= 1'b0;
            r_tmoCnt <= '0;
            r_tmo    <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmoCnt <= '0;
                    if (w_winValid) begin
                        r_grant  <= w_winIdx;
                        r_lba    <= bus.drv_lba[w_winSel];
                        r_blkCnt <= bus.drv_blk_cnt[w_winSel];
                        r_dirRd  <= bus.drv_rd[w_winSel];
                    end
                end
                REQ: begin
                    if (bus.sd_ack) begin
                        r_tmoCnt <= '0;
                    end else if (w_cntLast) begin
                        r_tmoCnt <= '0;
                        r_tmo    <= 1'b1;
                        r_last   <= r_grant;
                    end else begin
                        r_tmoCnt <= w_cntNext;
                    end
                end
                XFER: begin
                    if (!bus.sd_ack) r_last <= r_grant;
                end
                default: r_tmoCnt <= '0;
            endcase
        end
    end

    // Host strobes reach only the granted drive; buffer writes only while the transfer is live.
    always_comb begin
        w_sdRd   = 1'b0;
        w_sdWr   = 1'b0;
        w_ackWin = 1'b0;
        w_bufWin = 1'b0;
        case (r_state)
            REQ: begin
                w_sdRd   = r_dirRd;
                w_sdWr   = !r_dirRd;
                w_ackWin = 1'b1;
            end
            XFER: begin
                w_ackWin = 1'b1;
                w_bufWin = 1'b1;
            end
            default: ;
        endcase
        for (int i = 0; i < NDR; i++) begin
            w_drvAck[i]   = bus.sd_ack && w_ackWin && (r_grant == 2'(i));
            w_drvBufWr[i] = bus.sd_buff_wr && w_bufWin && (r_grant == 2'(i));
        end
    end

    assign bus.sd_rd       = w_sdRd;
    assign bus.sd_wr       = w_sdWr;
    assign bus.sd_lba      = r_lba;
    assign bus.sd_blk_cnt  = r_blkCnt;
    assign bus.sd_buff_din = bus.drv_buff_din[w_gSel];
    assign bus.drv_ack     = w_drvAck;
    assign bus.drv_buff_wr = w_drvBufWr;
    assign busy            = (r_state != IDLE);
    assign grant           = r_grant;
    assign tmo             = r_tmo;
endmodule
